// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// singlecycle_pkg (data-memory arbiter slice)
//
// Shared types and constants for the data-memory path:
//   DATA_BASE_ADDR / DATA_LAST_ADDR : byte window backed by the data SRAM
//   DmemArbState_e                  : arbiter FSM states
//   DmemPort_e                      : requester identity (LSU / debug loader)
//   DmemReq_s                       : one request's fields
//   in_data_window()                : window decode helper
// -----------------------------------------------------------------------------
package singlecycle_pkg;

    // 8 KiB window: (0x4000 - 0x2000) / 4 = 2048 words = 2^11.
    localparam logic [31:0] DATA_BASE_ADDR = 32'h0000_2000;
    localparam logic [31:0] DATA_LAST_ADDR = 32'h0000_4000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } DmemArbState_e;

    typedef enum logic {
        PORT_LSU = 1'b0,
        PORT_DBG = 1'b1
    } DmemPort_e;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
    } DmemReq_s;

    function automatic logic in_data_window(input logic [31:0] addr);
        return (addr >= DATA_BASE_ADDR) && (addr < DATA_LAST_ADDR);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//
// One requester's req/ack channel into the data-memory arbiter.
//   req, wen, addr, wdata, bmask : request, held stable until ack
//   ack                          : one-cycle completion pulse
//   rdata, err                   : response, valid while ack is high
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;
    logic        req;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, wen, addr, wdata, bmask,
        input  ack, rdata, err
    );

    modport slave (
        input  req, wen, addr, wdata, bmask,
        output ack, rdata, err
    );
endinterface

// File: rtl/dmem_arb_pick.sv
// -----------------------------------------------------------------------------
// dmem_arb_pick
//
// Winner select for the data-memory arbiter. LSU has priority, but after
// MAX_STREAK consecutive LSU grants made while the debug port was waiting,
// the debug port wins once.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   lsu_req_i      : LSU request pending
//   dbg_req_i      : debug request pending
//   grant_i        : a grant is being made this cycle (arbiter in IDLE)
//   winner_o       : selected port (combinational)
// -----------------------------------------------------------------------------
module dmem_arb_pick
    import singlecycle_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      lsu_req_i,
    input  logic      dbg_req_i,
    input  logic      grant_i,
    output DmemPort_e winner_o
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    logic [SW-1:0] streak_q;

    // NOTE: winner_o gets a default before any condition so no latch is inferred.
    always_comb begin
        winner_o = PORT_LSU;
        if (dbg_req_i && (!lsu_req_i || streak_q == SW'(MAX_STREAK))) begin
            winner_o = PORT_DBG;
        end
    end

    // The streak only counts LSU grants that actually made the debug port wait.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            streak_q <= '0;
        end else if (grant_i) begin
            if (winner_o == PORT_DBG || !dbg_req_i) begin
                streak_q <= '0;
            end else begin
                streak_q <= streak_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data SRAM between the pipeline LSU and the debug /
// program loader using a fixed-latency req/ack protocol.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   lsu              : LSU requester channel (slave side)
//   dbg              : debug/loader requester channel (slave side)
//   lsu_stall_o      : LSU request outstanding (to hazard unit)
//   sram_*           : SRAM macro interface (registered outputs)
//   perf_*           : saturating counters, present only when DMEM_ARB_PERF_EN
//                      is defined
// Sequence per access: IDLE (arbitrate, decode) -> ISSUE (cs high one cycle)
// -> WAIT (SRAM_LAT cycles) -> RESP (one-cycle ack). Out-of-window addresses
// skip straight from IDLE to RESP with err set and never touch the SRAM.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import singlecycle_pkg::*;
#(
    parameter int SRAM_LAT   = 1,
    parameter int MAX_STREAK = 4,
    parameter int SRAM_AW    = 11
) (
    input  logic               clk_i,
    input  logic               rst_i,
    dmem_arbiter_if.slave      lsu,
    dmem_arbiter_if.slave      dbg,
    output logic               lsu_stall_o,
    output logic               sram_cs_o,
    output logic               sram_we_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [31:0]        sram_wdata_o,
    output logic [3:0]         sram_bmask_o,
    input  logic [31:0]        sram_rdata_i
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]        perf_conflict_o,
    output logic [31:0]        perf_lsu_stall_o,
    output logic [31:0]        perf_err_o
`endif
);

    DmemArbState_e state_q;
    DmemPort_e     port_q;
    DmemPort_e     winner;
    DmemReq_s      sel;
    logic          wen_q;
    logic [2:0]    lat_cnt_q;
    logic          any_req;
    logic [31:0]   resp_data;

    assign any_req     = lsu.req | dbg.req;
    assign lsu_stall_o = lsu.req & ~lsu.ack;
    assign resp_data   = wen_q ? 32'h0 : sram_rdata_i;

    dmem_arb_pick #(
        .MAX_STREAK (MAX_STREAK)
    ) u_pick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .lsu_req_i (lsu.req),
        .dbg_req_i (dbg.req),
        .grant_i   (state_q == IDLE && any_req),
        .winner_o  (winner)
    );

    always_comb begin
        if (winner == PORT_DBG) begin
            sel = '{wen: dbg.wen, addr: dbg.addr, wdata: dbg.wdata, bmask: dbg.bmask};
        end else begin
            sel = '{wen: lsu.wen, addr: lsu.addr, wdata: lsu.wdata, bmask: lsu.bmask};
        end
    end

    // SRAM and response outputs are registered, so each is set on the edge
    // that enters the state in which it must be visible.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            port_q       <= PORT_LSU;
            wen_q        <= 1'b0;
            lat_cnt_q    <= '0;
            sram_cs_o    <= 1'b0;
            sram_we_o    <= 1'b0;
            sram_addr_o  <= '0;
            sram_wdata_o <= '0;
            sram_bmask_o <= '0;
            lsu.ack      <= 1'b0;
            lsu.rdata    <= '0;
            lsu.err      <= 1'b0;
            dbg.ack      <= 1'b0;
            dbg.rdata    <= '0;
            dbg.err      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        port_q <= winner;
                        wen_q  <= sel.wen;
                        if (in_data_window(sel.addr)) begin
                            state_q      <= ISSUE;
                            sram_cs_o    <= 1'b1;
                            sram_we_o    <= sel.wen;
                            // Word offset into the window; byte lane bits dropped.
                            sram_addr_o  <= SRAM_AW'((sel.addr - DATA_BASE_ADDR) >> 2);
                            sram_wdata_o <= sel.wdata;
                            sram_bmask_o <= sel.bmask;
                        end else begin
                            state_q <= RESP;
                            if (winner == PORT_DBG) begin
                                dbg.ack <= 1'b1;
                                dbg.err <= 1'b1;
                            end else begin
                                lsu.ack <= 1'b1;
                                lsu.err <= 1'b1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    sram_cs_o <= 1'b0;
                    sram_we_o <= 1'b0;
                    lat_cnt_q <= 3'(SRAM_LAT);
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt_q == 3'd1) begin
                        state_q <= RESP;
                        if (port_q == PORT_DBG) begin
                            dbg.ack   <= 1'b1;
                            dbg.rdata <= resp_data;
                        end else begin
                            lsu.ack   <= 1'b1;
                            lsu.rdata <= resp_data;
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    lsu.ack   <= 1'b0;
                    lsu.rdata <= '0;
                    lsu.err   <= 1'b0;
                    dbg.ack   <= 1'b0;
                    dbg.rdata <= '0;
                    dbg.err   <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_conflict_o  <= '0;
            perf_lsu_stall_o <= '0;
            perf_err_o       <= '0;
        end else begin
            if (state_q == IDLE && lsu.req && dbg.req && perf_conflict_o != '1) begin
                perf_conflict_o <= perf_conflict_o + 1'b1;
            end
            if (lsu_stall_o && perf_lsu_stall_o != '1) begin
                perf_lsu_stall_o <= perf_lsu_stall_o + 1'b1;
            end
            if (((lsu.ack && lsu.err) || (dbg.ack && dbg.err)) && perf_err_o != '1) begin
                perf_err_o <= perf_err_o + 1'b1;
            end
        end
    end
`endif

endmodule
